// File: rtl/imm_extend.sv
// ============================================================================
//  Module   : imm_extend
//  Brief    : RV32 immediate extractor/extender with optional output register.
//             Define IMMEXT_REG_OUT_EN to build the registered stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module imm_extend #(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [2:0]  i_immSrc,
    input  logic [31:0] i_inst,
    output logic [31:0] o_immExt,
    output logic [31:0] o_immExtQ,
    output logic        o_validQ
);

    localparam logic [2:0] c_SEL_I_LOAD = 3'b000;
    localparam logic [2:0] c_SEL_I_ALU  = 3'b001;
    localparam logic [2:0] c_SEL_SHAMT  = 3'b010;
    localparam logic [2:0] c_SEL_S      = 3'b011;
    localparam logic [2:0] c_SEL_U      = 3'b100;
    localparam logic [2:0] c_SEL_B      = 3'b101;
    localparam logic [2:0] c_SEL_I_JALR = 3'b110;
    localparam logic [2:0] c_SEL_J      = 3'b111;

    logic [31:0] w_immExt;
    logic        w_sign;

    assign w_sign = i_inst[31];

    // An unknown select falls to the default and propagates X rather than
    // masking it with a legal-looking immediate.
    always_comb begin
        w_immExt = 'x;
        case (i_immSrc)
            c_SEL_I_LOAD,
            c_SEL_I_ALU,
            c_SEL_I_JALR: w_immExt = {{20{w_sign}}, i_inst[31:20]};
            c_SEL_SHAMT:  w_immExt = {27'b0, i_inst[24:20]};
            c_SEL_S:      w_immExt = {{20{w_sign}}, i_inst[31:25], i_inst[11:7]};
            c_SEL_U:      w_immExt = {i_inst[31:12], 12'b0};
            c_SEL_B:      w_immExt = {{19{w_sign}}, i_inst[31], i_inst[7],
                                      i_inst[30:25], i_inst[11:8], 1'b0};
            c_SEL_J:      w_immExt = {{11{w_sign}}, i_inst[31], i_inst[19:12],
                                      i_inst[20], i_inst[30:21], 1'b0};
            default:      w_immExt = 'x;
        endcase
    end

    assign o_immExt = w_immExt;

`ifdef IMMEXT_REG_OUT_EN
    logic [31:0] r_immExtQ;
    logic        r_validQ;
    logic        w_unusedBits;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_immExtQ <= RST_VAL;
            r_validQ  <= 1'b0;
        end else begin
            if (i_en) begin
                r_immExtQ <= w_immExt;
            end
            r_validQ <= i_en;
        end
    end

    assign o_immExtQ    = r_immExtQ;
    assign o_validQ     = r_validQ;
    assign w_unusedBits = &{1'b0, i_inst[6:0]};
`else
    logic w_unusedBits;

    // Pass-through build: clock, reset and reset value are intentionally unused.
    assign o_immExtQ    = w_immExt;
    assign o_validQ     = i_en;
    assign w_unusedBits = &{1'b0, i_clk, i_rst_n, RST_VAL, i_inst[6:0]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_extend.sv
// ============================================================================
//  Module   : tb_imm_extend
//  Brief    : Directed self-checking bench for imm_extend (both build modes).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imm_extend;

    localparam logic [31:0] c_RST_VAL = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  immSrc;
    logic [31:0] inst;
    logic [31:0] immExt;
    logic [31:0] immExtQ;
    logic        validQ;

    int checks = 0;
    int errors = 0;

    imm_extend #(
        .RST_VAL (c_RST_VAL)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_immSrc  (immSrc),
        .i_inst    (inst),
        .o_immExt  (immExt),
        .o_immExtQ (immExtQ),
        .o_validQ  (validQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] ins;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{3'b000, 32'hFFF0_0000, 32'hFFFF_FFFF};
        vecs[1]  = '{3'b001, 32'h7FF0_0000, 32'h0000_07FF};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_001F};
        vecs[3]  = '{3'b011, 32'hFE00_0F80, 32'hFFFF_FFFF};
        vecs[4]  = '{3'b100, 32'hFFFF_F000, 32'hFFFF_F000};
        vecs[5]  = '{3'b101, 32'hF0F0_F0F0, 32'hFFFF_FF00};
        vecs[6]  = '{3'b111, 32'hF0F0_F0F0, 32'hFFF0_FF0E};
        vecs[7]  = '{3'b110, 32'h8010_0000, 32'hFFFF_F801};
        vecs[8]  = '{3'b000, 32'h0010_0000, 32'h0000_0001};
        vecs[9]  = '{3'b011, 32'h0200_0080, 32'h0000_0021};
        vecs[10] = '{3'b101, 32'h0000_0080, 32'h0000_0800};
        vecs[11] = '{3'b111, 32'h0010_0000, 32'h0000_0800};

        rst_n  = 1'b0;
        en     = 1'b0;
        immSrc = 3'b000;
        inst   = 32'h0;
        #2;

        // Combinational path, reset held so no capture can disturb it.
        for (int i = 0; i < 12; i++) begin
            immSrc = vecs[i].sel;
            inst   = vecs[i].ins;
            en     = i[0];
            #1;
            checkVal($sformatf("immExt[%0d]", i), immExt, vecs[i].exp);
`ifndef IMMEXT_REG_OUT_EN
            checkVal($sformatf("immExtQ[%0d]", i), immExtQ, vecs[i].exp);
            checkVal($sformatf("validQ[%0d]", i), {31'b0, validQ}, {31'b0, en});
`endif
        end

        // Unknown select must propagate X where the simulator models it.
        immSrc = 3'bxxx;
        inst   = 32'h0;
        #1;
        if ($isunknown(immSrc)) checkVal("selX", immExt, 32'hxxxx_xxxx);
        immSrc = 3'b000;
        en     = 1'b0;
        #1;

`ifdef IMMEXT_REG_OUT_EN
        @(negedge clk);
        checkVal("rstQ", immExtQ, c_RST_VAL);
        checkVal("rstValid", {31'b0, validQ}, 32'h0);
        rst_n = 1'b1;

        en = 1'b1; immSrc = 3'b100; inst = 32'h1234_5000;
        @(posedge clk); #1;
        checkVal("capQ", immExtQ, 32'h1234_5000);
        checkVal("capValid", {31'b0, validQ}, 32'h1);

        en = 1'b0; inst = 32'hABCD_E000;
        @(posedge clk); #1;
        checkVal("holdQ", immExtQ, 32'h1234_5000);
        checkVal("holdValid", {31'b0, validQ}, 32'h0);

        en = 1'b1; immSrc = 3'b001; inst = 32'h8000_0000;
        @(posedge clk); #1;
        checkVal("b2b0Q", immExtQ, 32'hFFFF_F800);
        immSrc = 3'b010; inst = 32'h0150_0000;
        @(posedge clk); #1;
        checkVal("b2b1Q", immExtQ, 32'h0000_0015);
        checkVal("b2b1Valid", {31'b0, validQ}, 32'h1);

        // Reset between edges clears at once and discards the pending capture.
        immSrc = 3'b100; inst = 32'h5555_5000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("asyncQ", immExtQ, c_RST_VAL);
        checkVal("asyncValid", {31'b0, validQ}, 32'h0);
        checkVal("immExtInRst", immExt, 32'h5555_5000);
        @(posedge clk); #1;
        checkVal("rstEdgeQ", immExtQ, c_RST_VAL);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkVal("postRstQ", immExtQ, 32'h5555_5000);
        checkVal("postRstValid", {31'b0, validQ}, 32'h1);
`else
        rst_n = 1'b1;
        en = 1'b1; immSrc = 3'b100; inst = 32'h1234_5000;
        #1;
        checkVal("passQ", immExtQ, 32'h1234_5000);
        checkVal("passValid", {31'b0, validQ}, 32'h1);
        en = 1'b0;
        @(posedge clk); #1;
        checkVal("passValidLow", {31'b0, validQ}, 32'h0);
        rst_n = 1'b0;
        #1;
        checkVal("passRstQ", immExtQ, 32'h1234_5000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
